// File: rtl/harris_nms.sv
// Threshold plus 3x3 non-maximum suppression on a raster-order Harris response
// stream. Reports surviving corners as coordinate strobes and keeps a
// per-frame corner count.
module harris_nms #(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned RW     = 32,
  parameter int          THRESH = 1000,
  parameter int unsigned CW     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [RW-1:0]         resp,
  input  logic                         resp_valid,
  output logic                         corner_valid,
  output logic [$clog2(IMG_W)-1:0]     corner_x,
  output logic [$clog2(IMG_H)-1:0]     corner_y,
  output logic                         frame_done,
  output logic [CW-1:0]                corner_count
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam logic signed [RW-1:0] THR = RW'(THRESH);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [CW-1:0] cnt_q;

  // Line buffers: lb1 holds row y-1, lb2 holds row y-2 (indexed by column).
  logic signed [RW-1:0] lb1 [IMG_W];
  logic signed [RW-1:0] lb2 [IMG_W];

  // Previous two window columns (x-1 and x-2); index 0 top, 1 middle, 2 bottom.
  logic signed [RW-1:0] c1 [3];
  logic signed [RW-1:0] c2 [3];

  logic signed [RW-1:0] top_n;
  logic signed [RW-1:0] mid_n;
  logic signed [RW-1:0] centre;
  logic                 peak_c;
  logic                 eval_c;
  logic                 hit_c;
  logic                 last_c;
  logic [CW-1:0]        cnt_inc_c;

  // Incoming column is (lb2[x], lb1[x], resp); centre is the middle of column x-1.
  always_comb begin
    top_n  = lb2[x_q];
    mid_n  = lb1[x_q];
    centre = c1[1];
    // Strict against raster-earlier neighbours, >= against later ones, so a
    // flat plateau is reported only at its raster-earliest pixel.
    peak_c = (centre > THR)
          && (centre >  c2[0]) && (centre >  c1[0]) && (centre >  top_n)
          && (centre >  c2[1])
          && (centre >= mid_n)
          && (centre >= c2[2]) && (centre >= c1[2]) && (centre >= resp);
    eval_c    = resp_valid && (x_q >= XW'(2)) && (y_q >= YW'(2));
    hit_c     = eval_c && peak_c;
    last_c    = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
    cnt_inc_c = (hit_c && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;
  end

  // Line buffer storage; contents before row 2 are never evaluated, so no reset.
  always_ff @(posedge clk) begin
    if (resp_valid) begin
      lb1[x_q] <= resp;
      lb2[x_q] <= lb1[x_q];
    end
  end

  // Raster position counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (resp_valid) begin
      if (x_q == XW'(IMG_W - 1)) begin
        x_q <= '0;
        y_q <= (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Shift the 3x3 window one column per accepted pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        c1[i] <= '0;
        c2[i] <= '0;
      end
    end else if (resp_valid) begin
      for (int i = 0; i < 3; i++) c2[i] <= c1[i];
      c1[0] <= top_n;
      c1[1] <= mid_n;
      c1[2] <= resp;
    end
  end

  // Corner strobe and coordinates; coordinates hold when no corner fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      corner_valid <= 1'b0;
      corner_x     <= '0;
      corner_y     <= '0;
    end else begin
      corner_valid <= hit_c;
      if (hit_c) begin
        corner_x <= x_q - XW'(1);
        corner_y <= y_q - YW'(1);
      end
    end
  end

  // Frame completion pulse and saturating per-frame corner count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done   <= 1'b0;
      corner_count <= '0;
      cnt_q        <= '0;
    end else begin
      frame_done <= resp_valid && last_c;
      if (resp_valid) begin
        if (last_c) begin
          corner_count <= cnt_inc_c;
          cnt_q        <= '0;
        end else begin
          cnt_q <= cnt_inc_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_harris_nms.sv
// Bench for harris_nms: directed and random frames compared against an
// image-level model of the threshold and non-maximum suppression rules.
module tb_harris_nms;

  localparam int unsigned IMG_W  = 8;
  localparam int unsigned IMG_H  = 8;
  localparam int unsigned RW     = 32;
  localparam int          THRESH = 100;
  localparam int unsigned CW     = 3;
  localparam int          CMAX   = (1 << CW) - 1;

  logic                         clk;
  logic                         reset;
  logic signed [RW-1:0]         resp;
  logic                         resp_valid;
  logic                         corner_valid;
  logic [$clog2(IMG_W)-1:0]     corner_x;
  logic [$clog2(IMG_H)-1:0]     corner_y;
  logic                         frame_done;
  logic [CW-1:0]                corner_count;

  int vectors;
  int miscompares;
  int img [IMG_H][IMG_W];

  harris_nms #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .RW(RW), .THRESH(THRESH), .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .resp(resp),
    .resp_valid(resp_valid),
    .corner_valid(corner_valid),
    .corner_x(corner_x),
    .corner_y(corner_y),
    .frame_done(frame_done),
    .corner_count(corner_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Corner rule evaluated directly on the stored image.
  function automatic bit is_corner(input int cx, input int cy);
    int c;
    int n;
    bit earlier;
    c = img[cy][cx];
    if (c <= THRESH) return 1'b0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx == 0 && dy == 0) continue;
        n = img[cy + dy][cx + dx];
        earlier = (dy < 0) || (dy == 0 && dx < 0);
        if (earlier && !(c > n)) return 1'b0;
        if (!earlier && !(c >= n)) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic clear_img();
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) img[y][x] = 0;
  endtask

  task automatic gap_cycle();
    resp_valid = 1'b0;
    resp = RW'($urandom);
    @(posedge clk); #1;
    check("gap_corner_valid", 64'(corner_valid), 64'd0);
    check("gap_frame_done", 64'(frame_done), 64'd0);
  endtask

  // Stream the image; stop_after >= 0 aborts after that many pixels.
  task automatic run_frame(input int max_gap, input int stop_after);
    int  cnt_exp;
    int  g;
    bit  exp_c;
    bit  last;
    cnt_exp = 0;
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        if (y * IMG_W + x == stop_after) return;
        if (max_gap > 0) begin
          g = int'($urandom_range(0, max_gap));
          repeat (g) gap_cycle();
        end
        resp = RW'(img[y][x]);
        resp_valid = 1'b1;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        exp_c = (x >= 2 && y >= 2) && is_corner(x - 1, y - 1);
        if (exp_c && cnt_exp < CMAX) cnt_exp++;
        check("corner_valid", 64'(corner_valid), 64'(exp_c));
        if (exp_c) begin
          check("corner_x", 64'(corner_x), 64'(x - 1));
          check("corner_y", 64'(corner_y), 64'(y - 1));
        end
        last = (x == IMG_W - 1) && (y == IMG_H - 1);
        check("frame_done", 64'(frame_done), 64'(last));
        if (last) check("corner_count", 64'(corner_count), 64'(cnt_exp));
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    resp        = '0;
    resp_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_corner_valid", 64'(corner_valid), 64'd0);
    check("rst_corner_x", 64'(corner_x), 64'd0);
    check("rst_corner_y", 64'(corner_y), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_corner_count", 64'(corner_count), 64'd0);
    reset = 1'b0;

    // All-zero frame.
    clear_img();
    run_frame(0, -1);

    // Single interior peak.
    clear_img();
    img[5][5] = 1000;
    run_frame(0, -1);

    // Peaks only on the border.
    clear_img();
    img[3][0] = 1000;
    img[7][7] = 1000;
    run_frame(0, -1);

    // Flat plateau plus a peak equal to the threshold.
    clear_img();
    img[4][3] = 500;
    img[4][4] = 500;
    img[2][2] = 100;
    run_frame(0, -1);

    // Single peak with irregular input gaps.
    clear_img();
    img[5][5] = 1000;
    run_frame(5, -1);

    // Abort a frame partway with reset, then a clean frame.
    clear_img();
    img[5][2] = 1000;
    run_frame(0, 30);
    reset = 1'b1;
    #1;
    check("mid_rst_corner_valid", 64'(corner_valid), 64'd0);
    check("mid_rst_frame_done", 64'(frame_done), 64'd0);
    check("mid_rst_corner_count", 64'(corner_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_img();
    img[4][4] = 1000;
    run_frame(0, -1);

    // Random frames with frequent ties and negative responses.
    for (int f = 0; f < 6; f++) begin
      for (int y = 0; y < IMG_H; y++)
        for (int x = 0; x < IMG_W; x++)
          img[y][x] = int'($urandom_range(0, 8)) * 50 - 100;
      run_frame((f % 2 == 1) ? 3 : 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
